// File: rtl/clock_monitor.sv
// clock_monitor: measures the high, low and full period of a divided clock
// sampled in the clk_50 domain. Reports lock, sticky fault and stuck status.
// Optional build macro CLOCK_MONITOR_SYNC_EN inserts a 2-flop synchronizer
// on mon_clk ahead of edge detection (all responses shift by two cycles).
module clock_monitor #(
   parameter int unsigned HALF_PERIOD = 5,
   parameter int unsigned TOL         = 0,
   parameter int unsigned LOCK_COUNT  = 4,
   parameter int unsigned TIMEOUT     = 64,
   parameter int unsigned CW          = 8
) (
   input  logic          clk_50,
   input  logic          rst,
   input  logic          mon_clk,
   input  logic          clear_fault,
   output logic [CW-1:0] period,
   output logic          period_valid,
   output logic          locked,
   output logic          fault,
   output logic          stuck
);

   localparam int unsigned IW    = $clog2(TIMEOUT + 1);
   localparam int unsigned GW    = $clog2(LOCK_COUNT + 1);
   localparam int unsigned PH_LO = (HALF_PERIOD > TOL) ? HALF_PERIOD - TOL : 0;
   localparam int unsigned PH_HI = HALF_PERIOD + TOL;
   localparam logic [CW-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {ACQUIRE, HIGH, LOW} state_e;

   state_e        state_q, state_d;
   logic          mon;
   logic          mon_d_q;
   logic [CW-1:0] hi_cnt_q, hi_cnt_d;
   logic [CW-1:0] lo_cnt_q, lo_cnt_d;
   logic [CW-1:0] hi_len_q, hi_len_d;
   logic [IW-1:0] idle_q, idle_d;
   logic [GW-1:0] good_q, good_d;
   logic [CW-1:0] period_q, period_d;
   logic          pv_q, pv_d;
   logic          locked_q, locked_d;
   logic          fault_q, fault_d;
   logic          stuck_q, stuck_d;

   logic          rise, fall, good_period, set_fault;
   logic [CW-1:0] hi_inc, lo_inc, period_sat;
   logic [CW:0]   period_sum;
   logic [GW-1:0] good_inc;

`ifdef CLOCK_MONITOR_SYNC_EN
   logic [1:0] sync_q;

   // Two-stage synchronizer for the asynchronous monitored clock
   always_ff @(posedge clk_50) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[0], mon_clk};
   end

   assign mon = sync_q[1];
`else
   assign mon = mon_clk;
`endif

   assign rise = mon & ~mon_d_q;
   assign fall = ~mon & mon_d_q;

   assign hi_inc     = (hi_cnt_q == CNT_MAX) ? hi_cnt_q : hi_cnt_q + CW'(1);
   assign lo_inc     = (lo_cnt_q == CNT_MAX) ? lo_cnt_q : lo_cnt_q + CW'(1);
   assign period_sum = {1'b0, hi_len_q} + {1'b0, lo_cnt_q};
   assign period_sat = period_sum[CW] ? CNT_MAX : period_sum[CW-1:0];
   assign good_inc   = (good_q == GW'(LOCK_COUNT)) ? good_q : good_q + GW'(1);

   assign good_period = (32'(hi_len_q) >= PH_LO) && (32'(hi_len_q) <= PH_HI) &&
                        (32'(lo_cnt_q) >= PH_LO) && (32'(lo_cnt_q) <= PH_HI);

   // State and measurement registers
   always_ff @(posedge clk_50) begin
      if (rst) begin
         state_q  <= ACQUIRE;
         mon_d_q  <= 1'b0;
         hi_cnt_q <= '0;
         lo_cnt_q <= '0;
         hi_len_q <= '0;
         idle_q   <= '0;
         good_q   <= '0;
         period_q <= '0;
         pv_q     <= 1'b0;
         locked_q <= 1'b0;
         fault_q  <= 1'b0;
         stuck_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         mon_d_q  <= mon;
         hi_cnt_q <= hi_cnt_d;
         lo_cnt_q <= lo_cnt_d;
         hi_len_q <= hi_len_d;
         idle_q   <= idle_d;
         good_q   <= good_d;
         period_q <= period_d;
         pv_q     <= pv_d;
         locked_q <= locked_d;
         fault_q  <= fault_d;
         stuck_q  <= stuck_d;
      end
   end

   // Phase measurement FSM, period qualification and stuck detection
   always_comb begin
      state_d   = state_q;
      hi_cnt_d  = hi_cnt_q;
      lo_cnt_d  = lo_cnt_q;
      hi_len_d  = hi_len_q;
      idle_d    = idle_q;
      good_d    = good_q;
      period_d  = period_q;
      pv_d      = 1'b0;
      locked_d  = locked_q;
      stuck_d   = stuck_q;
      set_fault = 1'b0;

      case (state_q)
         ACQUIRE: begin
            if (rise) begin
               hi_cnt_d = CW'(1);
               state_d  = HIGH;
            end
         end
         HIGH: begin
            if (fall) begin
               hi_len_d = hi_cnt_q;
               lo_cnt_d = CW'(1);
               state_d  = LOW;
            end else if (mon) begin
               hi_cnt_d = hi_inc;
            end
         end
         LOW: begin
            if (rise) begin
               period_d = period_sat;
               pv_d     = 1'b1;
               hi_cnt_d = CW'(1);
               state_d  = HIGH;
               if (good_period) begin
                  good_d   = good_inc;
                  locked_d = (good_inc == GW'(LOCK_COUNT));
               end else begin
                  good_d    = '0;
                  locked_d  = 1'b0;
                  set_fault = 1'b1;
               end
            end else if (!mon) begin
               lo_cnt_d = lo_inc;
            end
         end
         default: state_d = ACQUIRE;
      endcase

      // Idle counter fires the stuck event once, on reaching TIMEOUT
      if (rise || fall) begin
         idle_d  = '0;
         stuck_d = 1'b0;
      end else if (idle_q != IW'(TIMEOUT)) begin
         idle_d = idle_q + IW'(1);
         if (idle_q == IW'(TIMEOUT - 1)) begin
            stuck_d   = 1'b1;
            set_fault = 1'b1;
            locked_d  = 1'b0;
            good_d    = '0;
            state_d   = ACQUIRE;
         end
      end

      // Setting beats clearing when both happen in one cycle
      if (set_fault)        fault_d = 1'b1;
      else if (clear_fault) fault_d = 1'b0;
      else                  fault_d = fault_q;
   end

   assign period       = period_q;
   assign period_valid = pv_q;
   assign locked       = locked_q;
   assign fault        = fault_q;
   assign stuck        = stuck_q;

endmodule

// File: tb/tb_clock_monitor.sv
// Scoreboard bench for clock_monitor: two instances (5/0 and 13/1 half
// period/tolerance), directed and random phase sequences, per-cycle compare
// against a run-length reference model of the measured clock.
module tb_clock_monitor;

   logic       clk_50 = 1'b0;
   logic       rst_s [2];
   logic       mon_s [2];
   logic       clr_s [2];
   logic [7:0] per_s [2];
   logic       pv_s  [2];
   logic       lk_s  [2];
   logic       ft_s  [2];
   logic       sk_s  [2];

   always #5 clk_50 = ~clk_50;

   clock_monitor u_dut0 (
      .clk_50(clk_50), .rst(rst_s[0]), .mon_clk(mon_s[0]), .clear_fault(clr_s[0]),
      .period(per_s[0]), .period_valid(pv_s[0]), .locked(lk_s[0]),
      .fault(ft_s[0]), .stuck(sk_s[0]));

   clock_monitor #(.HALF_PERIOD(13), .TOL(1)) u_dut1 (
      .clk_50(clk_50), .rst(rst_s[1]), .mon_clk(mon_s[1]), .clear_fault(clr_s[1]),
      .period(per_s[1]), .period_valid(pv_s[1]), .locked(lk_s[1]),
      .fault(ft_s[1]), .stuck(sk_s[1]));

   typedef struct packed {
      logic       pv;
      logic [7:0] period;
      logic       locked;
      logic       fault;
      logic       stuck;
   } exp_t;

   // Model keeps cycle stamps of the last rise/fall instead of counters
   typedef struct {
      bit prev;
      int cyc;
      int last_edge;
      int stage;      // 0: waiting for rise, 1: rise seen, 2: rise+fall seen
      int r0;
      int f;
      int good;
      bit locked;
      bit fault;
      bit stuck;
      bit pv;
      int period;
   } mdl_t;

   localparam int TIMEOUT = 64;
   localparam int LOCKN   = 4;

   mdl_t m [2];
   int   hp  [2] = '{5, 13};
   int   tol [2] = '{0, 1};
   exp_t q0[$];
   exp_t q1[$];
   int   tests = 0;
   int   fails = 0;
   bit   started = 1'b0;
   int   pulses = 0;

   function automatic int sat8(int x);
      return (x > 255) ? 255 : x;
   endfunction

   task automatic model_step(int i, bit r, bit mn, bit c);
      bit   rise, fall, set, ok;
      int   hi, lo;
      exp_t e;
      m[i].cyc++;
      if (r) begin
         m[i].prev = 0; m[i].last_edge = m[i].cyc; m[i].stage = 0;
         m[i].good = 0; m[i].locked = 0; m[i].fault = 0; m[i].stuck = 0;
         m[i].pv = 0; m[i].period = 0;
      end else begin
         rise = mn && !m[i].prev;
         fall = !mn && m[i].prev;
         m[i].prev = mn;
         m[i].pv = 0;
         set = 0;
         if (rise || fall) begin
            m[i].last_edge = m[i].cyc;
            m[i].stuck = 0;
         end
         if (rise) begin
            if (m[i].stage == 2) begin
               hi = sat8(m[i].f - m[i].r0);
               lo = sat8(m[i].cyc - m[i].f);
               m[i].period = sat8(hi + lo);
               m[i].pv = 1;
               ok = (hi >= hp[i] - tol[i]) && (hi <= hp[i] + tol[i]) &&
                    (lo >= hp[i] - tol[i]) && (lo <= hp[i] + tol[i]);
               if (ok) begin
                  if (m[i].good < LOCKN) m[i].good++;
                  m[i].locked = (m[i].good == LOCKN);
               end else begin
                  m[i].good = 0; m[i].locked = 0; set = 1;
               end
            end
            m[i].r0 = m[i].cyc;
            m[i].stage = 1;
         end
         if (fall && m[i].stage == 1) begin
            m[i].f = m[i].cyc;
            m[i].stage = 2;
         end
         if (!rise && !fall && (m[i].cyc - m[i].last_edge == TIMEOUT)) begin
            m[i].stuck = 1; m[i].locked = 0; m[i].good = 0; m[i].stage = 0; set = 1;
         end
         if (set)    m[i].fault = 1;
         else if (c) m[i].fault = 0;
      end
      e.pv = m[i].pv; e.period = 8'(m[i].period); e.locked = m[i].locked;
      e.fault = m[i].fault; e.stuck = m[i].stuck;
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   // One clk_50 cycle: drive the selected instance, hold the other in reset
   task automatic tick(int sel, bit r, bit mn, bit c);
      @(negedge clk_50);
      for (int i = 0; i < 2; i++) begin
         if (i == sel) begin
            rst_s[i] = r; mon_s[i] = mn; clr_s[i] = c;
            model_step(i, r, mn, c);
         end else begin
            rst_s[i] = 1'b1; mon_s[i] = 1'b0; clr_s[i] = 1'b0;
            model_step(i, 1'b1, 1'b0, 1'b0);
         end
      end
      started = 1'b1;
   endtask

   task automatic phase(int sel, bit lvl, int n, int clr_at = -1);
      for (int k = 0; k < n; k++) tick(sel, 1'b0, lvl, (k == clr_at));
   endtask

   task automatic toggles(int sel, int n, int h, int l);
      for (int k = 0; k < n; k++) begin
         phase(sel, 1'b1, h);
         phase(sel, 1'b0, l);
      end
   endtask

   // Monitor: pops one expected record per cycle and compares all outputs
   always @(posedge clk_50) begin
      #1;
      if (started) begin
         for (int i = 0; i < 2; i++) begin
            exp_t e, a;
            bit   empty;
            empty = (i == 0) ? (q0.size() == 0) : (q1.size() == 0);
            tests++;
            if (empty) begin
               fails++;
               $display("FAIL sb_underflow dut%0d at %0t: no expected entry queued", i, $time);
            end else begin
               e = (i == 0) ? q0.pop_front() : q1.pop_front();
               a = {pv_s[i], per_s[i], lk_s[i], ft_s[i], sk_s[i]};
               if (a.pv) pulses++;
               if (a !== e) begin
                  fails++;
                  $display("FAIL outputs dut%0d at %0t: got pv=%0b period=%0d locked=%0b fault=%0b stuck=%0b, expected pv=%0b period=%0d locked=%0b fault=%0b stuck=%0b",
                           i, $time, a.pv, a.period, a.locked, a.fault, a.stuck,
                           e.pv, e.period, e.locked, e.fault, e.stuck);
               end
            end
         end
      end
   end

   initial begin
      int lvl, n, ca;
      for (int i = 0; i < 2; i++) begin
         rst_s[i] = 1'b1; mon_s[i] = 1'b0; clr_s[i] = 1'b0;
         m[i] = '{default: 0};
      end

      // Instance 0: lock, stretched phase, clear, timeout, clear/set race, reset
      repeat (3) tick(0, 1'b1, 1'b0, 1'b0);
      toggles(0, 8, 5, 5);
      phase(0, 1'b1, 7); phase(0, 1'b0, 5);
      toggles(0, 5, 5, 5);
      phase(0, 1'b1, 5, 2); phase(0, 1'b0, 5);
      phase(0, 1'b1, 5); phase(0, 1'b0, 70);
      toggles(0, 6, 5, 5);
      phase(0, 1'b1, 5); phase(0, 1'b0, 3);
      tick(0, 1'b0, 1'b1, 1'b1); tick(0, 1'b0, 1'b1, 1'b1);
      phase(0, 1'b1, 3); phase(0, 1'b0, 5);
      toggles(0, 5, 5, 5);
      phase(0, 1'b1, 2); tick(0, 1'b1, 1'b1, 1'b0);
      phase(0, 1'b1, 3); phase(0, 1'b0, 5);
      toggles(0, 3, 5, 5);

      lvl = 1;
      repeat (60) begin
         n  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(60, 75)) : int'($urandom_range(3, 8));
         ca = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, n - 1)) : -1;
         phase(0, lvl[0], n, ca);
         if ($urandom_range(0, 29) == 0) tick(0, 1'b1, lvl[0], 1'b0);
         lvl = 1 - lvl;
      end

      // Instance 1: 13 +/- 1 tolerance boundaries
      repeat (2) tick(1, 1'b1, 1'b0, 1'b0);
      toggles(1, 6, 12, 14);
      phase(1, 1'b1, 15); phase(1, 1'b0, 13);
      toggles(1, 5, 13, 13);
      phase(1, 1'b1, 13, 0); phase(1, 1'b0, 13);
      lvl = 1;
      repeat (40) begin
         n  = int'($urandom_range(11, 16));
         ca = ($urandom_range(0, 7) == 0) ? 0 : -1;
         phase(1, lvl[0], n, ca);
         lvl = 1 - lvl;
      end

      @(posedge clk_50); #2;
      tests++;
      if (q0.size() != 0 || q1.size() != 0) begin
         fails++;
         $display("FAIL sb_drain: got %0d/%0d entries left, expected 0/0", q0.size(), q1.size());
      end
      tests++;
      if (pulses < 40) begin
         fails++;
         $display("FAIL pulse_count: got %0d period_valid pulses, expected at least 40", pulses);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
